// File: rtl/csr_bus_arbiter_if.sv
// rtl/csr_bus_arbiter_if.sv - requester and register-map signal bundle for csr_bus_arbiter
// Requester side: req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten (packed per
//   requester, slice i = [i*W +: W]) in; req_done (one-hot pulse), req_err, req_rd_data out.
// Register-map side: bus_req (strobe), bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten out;
//   bus_ready, bus_err, bus_rd_data, bus_stall_wr, bus_stall_rd in.
// master modport: the arbiter. slave modport: the requesters plus the register map.
interface csr_bus_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_is_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_biten;
    logic [NUM_REQ-1:0]            req_done;
    logic                          req_err;
    logic [DATA_WIDTH-1:0]         req_rd_data;

    logic                          bus_req;
    logic                          bus_req_is_wr;
    logic [ADDR_WIDTH-1:0]         bus_addr;
    logic [DATA_WIDTH-1:0]         bus_wr_data;
    logic [DATA_WIDTH-1:0]         bus_wr_biten;
    logic                          bus_ready;
    logic                          bus_err;
    logic [DATA_WIDTH-1:0]         bus_rd_data;
    logic                          bus_stall_wr;
    logic                          bus_stall_rd;

    modport master (
        input  req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
        output req_done, req_err, req_rd_data,
        output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        input  bus_ready, bus_err, bus_rd_data, bus_stall_wr, bus_stall_rd
    );

    modport slave (
        output req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
        input  req_done, req_err, req_rd_data,
        input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        output bus_ready, bus_err, bus_rd_data, bus_stall_wr, bus_stall_rd
    );
endinterface

// File: rtl/csr_bus_arbiter.sv
// rtl/csr_bus_arbiter.sv - round-robin arbiter sharing one CSR register-map bus
// Ports: clk, rst (asynchronous, active-high); csr (csr_bus_arbiter_if.master) carrying the
//   requester commands/responses and the register-map request/response handshake.
// One access outstanding at a time; grant held until bus_ready. Optional bus_ready timeout
//   enabled by defining CSR_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module csr_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    csr_bus_arbiter_if.master csr
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("csr_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic                    bus_req_is_wr_q, bus_req_is_wr_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wr_data_q, bus_wr_data_d;
    logic [DATA_WIDTH-1:0]   bus_wr_biten_q, bus_wr_biten_d;
    logic [NUM_REQ-1:0]      req_done_q, req_done_d;
    logic                    req_err_q, req_err_d;
    logic [DATA_WIDTH-1:0]   req_rd_data_q, req_rd_data_d;
`ifdef CSR_ARB_TIMEOUT_EN
    logic [15:0]             tmo_cnt_q, tmo_cnt_d;
`endif

    logic [NUM_REQ-1:0]      eligible;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    int                      cand;
    logic                    stalled;
    logic                    issue;
    logic                    finish;
    logic                    fin_err;
    logic [DATA_WIDTH-1:0]   fin_data;
    logic [DATA_WIDTH-1:0]   rsp_data;

    // Winner search: scan from the farthest candidate back to rr_ptr so the
    // last hit is the first valid index at or after rr_ptr, cyclically.
    always_comb begin
        eligible  = csr.req_valid & ~req_done_q;  // requester finishing this cycle is masked
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (eligible[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign stalled  = bus_req_is_wr_q ? csr.bus_stall_wr : csr.bus_stall_rd;
    assign issue    = (state_q == ISSUE) && !stalled;
    assign rsp_data = bus_req_is_wr_q ? '0 : csr.bus_rd_data;

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        bus_req_is_wr_d = bus_req_is_wr_q;
        bus_addr_d      = bus_addr_q;
        bus_wr_data_d   = bus_wr_data_q;
        bus_wr_biten_d  = bus_wr_biten_q;
        req_done_d      = '0;
        req_err_d       = 1'b0;
        req_rd_data_d   = '0;
        finish          = 1'b0;
        fin_err         = 1'b0;
        fin_data        = '0;
`ifdef CSR_ARB_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d         = ISSUE;
                    grant_d         = win_idx;
                    bus_req_is_wr_d = csr.req_is_wr[win_idx];
                    bus_addr_d      = csr.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    bus_wr_data_d   = csr.req_wr_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    bus_wr_biten_d  = csr.req_wr_biten[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            ISSUE: begin
                // bus_ready is only honoured once the strobe actually goes out.
                if (issue) begin
                    if (csr.bus_ready) begin
                        finish   = 1'b1;
                        fin_err  = csr.bus_err;
                        fin_data = rsp_data;
                    end else begin
                        state_d = WAIT;
`ifdef CSR_ARB_TIMEOUT_EN
                        tmo_cnt_d = 16'd1;
                        if (TIMEOUT_CYCLES == 1) begin
                            finish  = 1'b1;
                            fin_err = 1'b1;
                        end
`endif
                    end
                end
            end
            WAIT: begin
                if (csr.bus_ready) begin
                    finish   = 1'b1;
                    fin_err  = csr.bus_err;
                    fin_data = rsp_data;
                end
`ifdef CSR_ARB_TIMEOUT_EN
                // tmo_cnt_q counts cycles elapsed since bus_req.
                else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d       = IDLE;
            req_done_d    = NUM_REQ'(1) << grant_q;
            req_err_d     = fin_err;
            req_rd_data_d = fin_data;
            rr_ptr_d      = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            bus_req_is_wr_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_wr_data_q   <= '0;
            bus_wr_biten_q  <= '0;
            req_done_q      <= '0;
            req_err_q       <= 1'b0;
            req_rd_data_q   <= '0;
`ifdef CSR_ARB_TIMEOUT_EN
            tmo_cnt_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            bus_req_is_wr_q <= bus_req_is_wr_d;
            bus_addr_q      <= bus_addr_d;
            bus_wr_data_q   <= bus_wr_data_d;
            bus_wr_biten_q  <= bus_wr_biten_d;
            req_done_q      <= req_done_d;
            req_err_q       <= req_err_d;
            req_rd_data_q   <= req_rd_data_d;
`ifdef CSR_ARB_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
`endif
        end
    end

    assign csr.bus_req       = issue;
    assign csr.bus_req_is_wr = bus_req_is_wr_q;
    assign csr.bus_addr      = bus_addr_q;
    assign csr.bus_wr_data   = bus_wr_data_q;
    assign csr.bus_wr_biten  = bus_wr_biten_q;
    assign csr.req_done      = req_done_q;
    assign csr.req_err       = req_err_q;
    assign csr.req_rd_data   = req_rd_data_q;
endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb/tb_csr_bus_arbiter.sv - self-checking bench for csr_bus_arbiter
module tb_csr_bus_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 11;
`ifdef CSR_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 0;  // 0: model never times out
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_bus_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) csr ();

    csr_bus_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TMO == 0 ? 255 : TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .csr(csr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one access in flight, identified by its owner,
    // its captured command and how many cycles have elapsed since its strobe.
    int              m_ptr, m_g, m_age, m_done, idx;
    bit              m_active, m_issued, m_err, m_wr, fin, ferr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data, m_biten, m_rd, frd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_g = 0; m_age = 0; m_done = -1;
            m_active = 0; m_issued = 0; m_err = 0; m_wr = 0;
            m_addr = '0; m_data = '0; m_biten = '0; m_rd = '0;
        end else begin
            fin = 0; ferr = 0; frd = '0;
            if (!m_active) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (!m_active && csr.req_valid[idx] && idx != m_done) begin
                        m_active = 1; m_issued = 0; m_age = 0; m_g = idx;
                        m_wr    = csr.req_is_wr[idx];
                        m_addr  = csr.req_addr[idx*AW +: AW];
                        m_data  = csr.req_wr_data[idx*DW +: DW];
                        m_biten = csr.req_wr_biten[idx*DW +: DW];
                    end
                end
            end else if (!m_issued && (m_wr ? csr.bus_stall_wr : csr.bus_stall_rd)) begin
                // held back, nothing leaves
            end else begin
                m_issued = 1;
                m_age++;
                if (csr.bus_ready) begin
                    fin = 1; ferr = csr.bus_err; frd = m_wr ? '0 : csr.bus_rd_data;
                end else if (TMO > 0 && m_age >= TMO) begin
                    fin = 1; ferr = 1; frd = '0;
                end
            end
            if (fin) begin
                m_done = m_g;
                m_ptr = (m_g + 1) % NR;
                m_active = 0; m_issued = 0;
            end else begin
                m_done = -1;
            end
            m_err = fin ? ferr : 1'b0;
            m_rd  = fin ? frd : '0;
        end
    end

    always @(negedge clk) begin
        chk("req_done", csr.req_done, (m_done >= 0) ? (64'd1 << m_done) : 64'd0);
        chk("req_err", csr.req_err, m_err);
        chk("req_rd_data", csr.req_rd_data, m_rd);
        chk("bus_req", csr.bus_req,
            m_active && !m_issued && !(m_wr ? csr.bus_stall_wr : csr.bus_stall_rd));
        chk("bus_req_is_wr", csr.bus_req_is_wr, m_wr);
        chk("bus_addr", csr.bus_addr, m_addr);
        chk("bus_wr_data", csr.bus_wr_data, m_data);
        chk("bus_wr_biten", csr.bus_wr_biten, m_biten);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cmd(input int i, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] be);
        csr.req_is_wr[i]             = wr;
        csr.req_addr[i*AW +: AW]     = a;
        csr.req_wr_data[i*DW +: DW]  = d;
        csr.req_wr_biten[i*DW +: DW] = be;
    endtask

    // Waits (bounded) for bus_req, answers after wait_cyc cycles, returns the response.
    task automatic serve(input logic [DW-1:0] rd, input bit err, input int wait_cyc,
                         output int lat, output logic [NR-1:0] done, output bit rerr,
                         output logic [DW-1:0] rdata, output logic [AW-1:0] addr);
        lat = -1; done = '0; rerr = 0; rdata = '0; addr = '0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (csr.bus_req) begin
                lat = k; addr = csr.bus_addr;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            chk("bus_req_seen", csr.bus_req, 1);
            return;
        end
        for (int k = 0; k < wait_cyc; k++) tick();
        csr.bus_ready = 1; csr.bus_err = err; csr.bus_rd_data = rd;
        tick();
        csr.bus_ready = 0; csr.bus_err = 0;
        done = csr.req_done; rerr = csr.req_err; rdata = csr.req_rd_data;
        csr.req_valid = csr.req_valid & ~csr.req_done;
    endtask

    int              lat, sc, pct;
    logic [NR-1:0]   done, hold;
    bit              rerr;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   addr;

    initial begin
        csr.req_valid = '0; csr.req_is_wr = '0; csr.req_addr = '0;
        csr.req_wr_data = '0; csr.req_wr_biten = '0;
        csr.bus_ready = 0; csr.bus_err = 0; csr.bus_rd_data = '0;
        csr.bus_stall_wr = 0; csr.bus_stall_rd = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;

        // write from req0, ready three cycles after the strobe
        set_cmd(0, 1, 11'h010, 32'hDEADBEEF, 32'hFFFFFFFF);
        csr.req_valid = 2'b01;
        serve(32'h0000CAFE, 0, 3, lat, done, rerr, rdata, addr);
        chk("t1_latency", lat, 1);
        chk("t1_addr", addr, 11'h010);
        chk("t1_done", done, 2'b01);
        chk("t1_err", rerr, 0);
        chk("t1_rd_data", rdata, 0);

        // two reads right after reset: req0 first, then req1 two cycles later
        tick(); rst = 1; tick(); rst = 0;
        set_cmd(0, 0, 11'h020, 32'h0, 32'h0);
        set_cmd(1, 0, 11'h024, 32'h0, 32'h0);
        csr.req_valid = 2'b11;
        serve(32'h11, 0, 0, lat, done, rerr, rdata, addr);
        chk("t2a_latency", lat, 1);
        chk("t2a_done", done, 2'b01);
        chk("t2a_rd_data", rdata, 32'h11);
        serve(32'h22, 0, 0, lat, done, rerr, rdata, addr);
        chk("t2b_spacing", lat, 1);
        chk("t2b_done", done, 2'b10);
        chk("t2b_rd_data", rdata, 32'h22);
        chk("t2b_addr", addr, 11'h024);

        // req1 write stalled five cycles, req0 read queued behind it
        tick();
        csr.bus_stall_wr = 1;
        set_cmd(1, 1, 11'h030, 32'h12345678, 32'h0000FFFF);
        csr.req_valid = 2'b10;
        sc = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                set_cmd(0, 0, 11'h034, 32'h0, 32'h0);
                csr.req_valid = 2'b11;
            end
            sc += int'(csr.bus_req);
        end
        tick();
        csr.bus_stall_wr = 0;
        chk("t3_stalled_pulses", sc, 0);
        serve(32'hFFFF, 0, 0, lat, done, rerr, rdata, addr);
        chk("t3_release_latency", lat, 0);
        chk("t3_done", done, 2'b10);
        chk("t3_addr", addr, 11'h030);
        chk("t3_wr_rd_data", rdata, 0);
        serve(32'h33, 0, 1, lat, done, rerr, rdata, addr);
        chk("t3_queued_done", done, 2'b01);
        chk("t3_queued_addr", addr, 11'h034);

        // read with error, then a clean read
        tick();
        set_cmd(0, 0, 11'h040, 32'h0, 32'h0);
        csr.req_valid = 2'b01;
        serve(32'h5A5A5A5A, 1, 1, lat, done, rerr, rdata, addr);
        chk("t4_err", rerr, 1);
        chk("t4_done", done, 2'b01);
        tick();
        csr.req_valid = 2'b01;
        serve(32'h77, 0, 0, lat, done, rerr, rdata, addr);
        chk("t4_next_err", rerr, 0);
        chk("t4_next_rd_data", rdata, 32'h77);

`ifdef CSR_ARB_TIMEOUT_EN
        // no bus_ready at all: error completion eight cycles after the strobe
        tick();
        set_cmd(0, 0, 11'h050, 32'h0, 32'h0);
        csr.bus_rd_data = 32'hFFFF0000;
        csr.req_valid = 2'b01;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            tick();
            if (csr.bus_req) lat = k;
        end
        chk("t5_strobe_seen", lat, 0);
        sc = -1;
        for (int k = 1; k <= 20 && sc < 0; k++) begin
            tick();
            if (csr.req_done != '0) sc = k;
        end
        chk("t5_timeout_cycles", sc, 8);
        chk("t5_done", csr.req_done, 2'b01);
        chk("t5_err", csr.req_err, 1);
        chk("t5_rd_data", csr.req_rd_data, 0);
        csr.req_valid = 2'b00;
        tick();
        csr.req_valid = 2'b01;
        serve(32'h1, 0, 0, lat, done, rerr, rdata, addr);
        chk("t5_idle_after", lat, 1);
`endif

        // reset while waiting; afterwards requester 0 wins even though rr_ptr was 1
        tick();
        set_cmd(1, 0, 11'h060, 32'h0, 32'h0);
        csr.req_valid = 2'b10;
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            tick();
            if (csr.bus_req) lat = k;
        end
        chk("t6_strobe_seen", lat, 0);
        tick();
        set_cmd(0, 0, 11'h064, 32'h0, 32'h0);
        csr.req_valid = 2'b11;
        rst = 1;
        #1;
        chk("t6_rst_done", csr.req_done, 0);
        chk("t6_rst_bus_req", csr.bus_req, 0);
        chk("t6_rst_bus_addr", csr.bus_addr, 0);
        chk("t6_rst_rd_data", csr.req_rd_data, 0);
        tick(); tick();
        rst = 0;
        serve(32'h99, 0, 0, lat, done, rerr, rdata, addr);
        chk("t6_first_done", done, 2'b01);
        chk("t6_first_addr", addr, 11'h064);
        serve(32'h98, 0, 0, lat, done, rerr, rdata, addr);
        chk("t6_second_done", done, 2'b10);
        chk("t6_second_addr", addr, 11'h060);
        tick();
        csr.req_valid = '0;

        // randomized traffic against the reference model
        hold = '0;
        pct = 30;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 500 == 0) pct = $urandom_range(2, 40);
            for (int i = 0; i < NR; i++) begin
                if (hold[i]) begin
                    if (csr.req_done[i]) begin
                        hold[i] = 0;
                        csr.req_valid[i] = 1'($urandom_range(0, 1));
                    end
                    if ($urandom_range(0, 5) == 0 || !hold[i])
                        set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom);
                end else if ($urandom_range(0, 2) == 0) begin
                    hold[i] = 1;
                    csr.req_valid[i] = 1;
                    set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom);
                end else begin
                    csr.req_valid[i] = 0;
                end
            end
            csr.bus_ready    = ($urandom_range(0, 99) < pct);
            csr.bus_err      = ($urandom_range(0, 3) == 0);
            csr.bus_rd_data  = $urandom;
            csr.bus_stall_wr = ($urandom_range(0, 4) == 0);
            csr.bus_stall_rd = ($urandom_range(0, 4) == 0);
        end
        tick();
        csr.req_valid = '0; csr.bus_ready = 0; csr.bus_stall_wr = 0; csr.bus_stall_rd = 0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
